// File: rtl/v2f_seq_divmod_if.sv
// Operand/result handshake bundle for v2f_seq_divmod.
// The master issues operands and drains results; the slave is the divider.
interface v2f_seq_divmod_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/v2f_seq_divmod.sv
// Multi-cycle restoring divider producing quotient and remainder, one quotient
// bit per cycle, with optional two's-complement mode and defined /0 and overflow results.
module v2f_seq_divmod #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  v2f_seq_divmod_if.slave io_bus
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state,     w_state_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0] r_quo,       w_quo_nxt;
  logic [WIDTH-1:0] r_rem,       w_rem_nxt;
  logic             r_dbz,       w_dbz_nxt;
  logic [WIDTH-1:0] r_dvd,       w_dvd_nxt;
  logic [WIDTH-1:0] r_dvs,       w_dvs_nxt;
  logic [WIDTH-1:0] r_prem,      w_prem_nxt;
  logic [CW-1:0]    r_cnt,       w_cnt_nxt;
  logic             r_neg_q,     w_neg_q_nxt;
  logic             r_neg_r,     w_neg_r_nxt;

  // One restoring step: dividend register doubles as the quotient shift register.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_prem_step;
  logic [WIDTH-1:0] w_q_raw;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_shift     = {r_prem, r_dvd[WIDTH-1]};
  assign w_diff      = w_shift - {1'b0, r_dvs};
  assign w_qbit      = ~w_diff[WIDTH];
  assign w_prem_step = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_raw     = {r_dvd[WIDTH-2:0], w_qbit};

  assign w_a_neg = SIGNED && io_bus.a[WIDTH-1];
  assign w_b_neg = SIGNED && io_bus.b[WIDTH-1];
  assign w_abs_a = w_a_neg ? WIDTH'(-io_bus.a) : io_bus.a;
  assign w_abs_b = w_b_neg ? WIDTH'(-io_bus.b) : io_bus.b;

  always_comb begin
    w_state_nxt = r_state;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dbz_nxt   = r_dbz;
    w_dvd_nxt   = r_dvd;
    w_dvs_nxt   = r_dvs;
    w_prem_nxt  = r_prem;
    w_cnt_nxt   = r_cnt;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;

    case (r_state)
      S_IDLE: begin
        if (io_bus.in_valid && r_in_ready) begin
          if (io_bus.b == '0) begin
            w_quo_nxt   = '1;
            w_rem_nxt   = io_bus.a;
            w_dbz_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (SIGNED && (io_bus.a == MIN_VAL) && (io_bus.b == '1)) begin
            w_quo_nxt   = MIN_VAL;
            w_rem_nxt   = '0;
            w_dbz_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_dvd_nxt   = w_abs_a;
            w_dvs_nxt   = w_abs_b;
            w_prem_nxt  = '0;
            w_cnt_nxt   = CW'(WIDTH - 1);
            w_neg_q_nxt = w_a_neg ^ w_b_neg;
            w_neg_r_nxt = w_a_neg;
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_dvd_nxt  = w_q_raw;
        w_prem_nxt = w_prem_step;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_quo_nxt   = r_neg_q ? WIDTH'(-w_q_raw) : w_q_raw;
          w_rem_nxt   = r_neg_r ? WIDTH'(-w_prem_step) : w_prem_step;
          w_dbz_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (io_bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_quo       <= w_quo_nxt;
      r_rem       <= w_rem_nxt;
      r_dbz       <= w_dbz_nxt;
      r_dvd       <= w_dvd_nxt;
      r_dvs       <= w_dvs_nxt;
      r_prem      <= w_prem_nxt;
      r_cnt       <= w_cnt_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
    end
  end

  assign io_bus.in_ready    = r_in_ready;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.quotient    = r_quo;
  assign io_bus.remainder   = r_rem;
  assign io_bus.div_by_zero = r_dbz;
endmodule
